// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS pipeline types for the data-memory controller
package mips_pkg;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_BUSY = 2'd1,
    DMEM_DONE = 2'd2
  } dmem_state_t;

  // Size 11 falls into the word arm, matching how the lanes treat it.
  function automatic logic dmem_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      MEM_BYTE: return 1'b0;
      MEM_HALF: return addr_lo[0];
      default:  return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// rtl/dmem_ctrl_if.sv - request/acknowledge data-bus interface between dmem_ctrl and memory
interface dmem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [31:0]       bus_wdata;
  logic              bus_ack;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/dmem_lane.sv
// rtl/dmem_lane.sv - combinational byte-lane steering: enables, store replication, load extension
module dmem_lane
  import mips_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);
  logic [1:0]  off;
  logic [31:0] shifted;

  always_comb begin
    off       = 2'b00;
    be        = 4'b1111;
    wdata_rep = wdata;
    case (size)
      MEM_BYTE: begin
        off       = addr_lo;
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      MEM_HALF: begin
        // Halves are forced to 2-byte alignment; addr_lo[0] never moves the lane.
        off       = {addr_lo[1], 1'b0};
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
      end
      default: ;
    endcase

    shifted = rword >> {off, 3'b000};
    case (size)
      MEM_BYTE: rdata_ext = is_unsigned ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      MEM_HALF: rdata_ext = is_unsigned ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default:  rdata_ext = shifted;
    endcase
  end
endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - MEM-stage load/store bus controller; DMEM_ALIGN_CHECK_EN traps misaligned half/word accesses
module dmem_ctrl
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read_MEM,
  input  logic              mem_write_MEM,
  input  logic [1:0]        mem_size_MEM,
  input  logic              mem_unsigned_MEM,
  input  logic [ADDR_W-1:0] addr_MEM,
  input  logic [31:0]       wdata_MEM,
  output logic [31:0]       rdata_MEM,
  output logic              mem_stall_MEM,
  output logic              misalign_MEM,
  dmem_ctrl_if.master       bus
);
  dmem_state_t       state;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata;
  logic [31:0]       lane_rdata;
  logic              acc;

  assign acc           = mem_read_MEM | mem_write_MEM;
  assign mem_stall_MEM = acc & (state != DMEM_DONE);

  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wdata_q;

  // MEM inputs are frozen while stalled, so one lane instance serves both issue and ack.
  dmem_lane u_lane (
    .size        (mem_size_MEM),
    .addr_lo     (addr_MEM[1:0]),
    .is_unsigned (mem_unsigned_MEM),
    .wdata       (wdata_MEM),
    .rword       (bus.bus_rdata),
    .be          (lane_be),
    .wdata_rep   (lane_wdata),
    .rdata_ext   (lane_rdata)
  );

`ifdef DMEM_ALIGN_CHECK_EN
  logic misalign_q;
  assign misalign_MEM = misalign_q;
`else
  assign misalign_MEM = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= DMEM_IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= 4'b0000;
      wdata_q   <= 32'd0;
      rdata_MEM <= 32'd0;
`ifdef DMEM_ALIGN_CHECK_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      case (state)
        DMEM_IDLE: begin
          if (acc) begin
`ifdef DMEM_ALIGN_CHECK_EN
            if (dmem_misaligned(mem_size_MEM, addr_MEM[1:0])) begin
              state      <= DMEM_DONE;
              misalign_q <= 1'b1;
            end else
`endif
            begin
              state   <= DMEM_BUSY;
              req_q   <= 1'b1;
              we_q    <= mem_write_MEM;
              addr_q  <= {addr_MEM[ADDR_W-1:2], 2'b00};
              be_q    <= lane_be;
              wdata_q <= lane_wdata;
            end
          end
        end
        DMEM_BUSY: begin
          if (bus.bus_ack) begin
            state <= DMEM_DONE;
            req_q <= 1'b0;
            if (!we_q) rdata_MEM <= lane_rdata;
          end
        end
        DMEM_DONE: begin
          state <= DMEM_IDLE;
`ifdef DMEM_ALIGN_CHECK_EN
          misalign_q <= 1'b0;
`endif
        end
        default: state <= DMEM_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed self-checking bench for dmem_ctrl
module tb_dmem_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read_MEM = 1'b0;
  logic        mem_write_MEM = 1'b0;
  logic [1:0]  mem_size_MEM = 2'b00;
  logic        mem_unsigned_MEM = 1'b0;
  logic [31:0] addr_MEM = 32'd0;
  logic [31:0] wdata_MEM = 32'd0;
  logic [31:0] rdata_MEM;
  logic        mem_stall_MEM;
  logic        misalign_MEM;

  int tests = 0;
  int fails = 0;

  int          o_stalls;
  int          o_reqs;
  logic [3:0]  o_be;
  logic [31:0] o_addr;
  logic [31:0] o_wd;
  logic        o_we;
  logic        o_stable;
  logic        o_to;

  always #5 clk = ~clk;

  dmem_ctrl_if #(.ADDR_W(32)) bus ();

  dmem_ctrl #(.ADDR_W(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .mem_read_MEM     (mem_read_MEM),
    .mem_write_MEM    (mem_write_MEM),
    .mem_size_MEM     (mem_size_MEM),
    .mem_unsigned_MEM (mem_unsigned_MEM),
    .addr_MEM         (addr_MEM),
    .wdata_MEM        (wdata_MEM),
    .rdata_MEM        (rdata_MEM),
    .mem_stall_MEM    (mem_stall_MEM),
    .misalign_MEM     (misalign_MEM),
    .bus              (bus)
  );

  // Presents one access, plays the memory, and returns in the first non-stalled cycle.
  task automatic run_access(
    input  logic rd, input logic wr, input logic [1:0] sz, input logic uns,
    input  logic [31:0] a, input logic [31:0] wd, input int ack_wait, input logic [31:0] rw,
    output int stalls, output int reqs, output logic [3:0] be, output logic [31:0] baddr,
    output logic [31:0] bwd, output logic bwe, output logic stable, output logic timeout);
    stalls = 0; reqs = 0; be = 4'd0; baddr = 32'd0; bwd = 32'd0; bwe = 1'b0;
    stable = 1'b1; timeout = 1'b1;
    mem_read_MEM = rd; mem_write_MEM = wr; mem_size_MEM = sz; mem_unsigned_MEM = uns;
    addr_MEM = a; wdata_MEM = wd;
    #1;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (!mem_stall_MEM) begin
        timeout = 1'b0;
        break;
      end
      stalls++;
      if (bus.bus_req) begin
        if (reqs == 0) begin
          be = bus.bus_be; baddr = bus.bus_addr; bwd = bus.bus_wdata; bwe = bus.bus_we;
        end else if (bus.bus_be !== be || bus.bus_addr !== baddr || bus.bus_wdata !== bwd || bus.bus_we !== bwe) begin
          stable = 1'b0;
        end
        reqs++;
        if (reqs > ack_wait) begin
          bus.bus_ack = 1'b1;
          bus.bus_rdata = rw;
        end
      end
      @(negedge clk);
      bus.bus_ack = 1'b0;
      #1;
    end
    mem_read_MEM = 1'b0;
    mem_write_MEM = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    tests++; if (bus.bus_req !== 1'b0) begin fails++; $display("FAIL reset_req got %b exp 0", bus.bus_req); end
    tests++; if (bus.bus_we !== 1'b0) begin fails++; $display("FAIL reset_we got %b exp 0", bus.bus_we); end
    tests++; if (bus.bus_be !== 4'h0) begin fails++; $display("FAIL reset_be got %h exp 0", bus.bus_be); end
    tests++; if (bus.bus_addr !== 32'h0) begin fails++; $display("FAIL reset_addr got %h exp 0", bus.bus_addr); end
    tests++; if (bus.bus_wdata !== 32'h0) begin fails++; $display("FAIL reset_wdata got %h exp 0", bus.bus_wdata); end
    tests++; if (rdata_MEM !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h exp 0", rdata_MEM); end
    tests++; if (misalign_MEM !== 1'b0) begin fails++; $display("FAIL reset_misalign got %b exp 0", misalign_MEM); end
    tests++; if (mem_stall_MEM !== 1'b0) begin fails++; $display("FAIL reset_stall got %b exp 0", mem_stall_MEM); end
    rst_n = 1'b1;
  endtask

  task automatic test_lw;
    @(negedge clk);
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, 32'hDEADBEEF,
               o_stalls, o_reqs, o_be, o_addr, o_wd, o_we, o_stable, o_to);
    tests++; if (o_to !== 1'b0) begin fails++; $display("FAIL lw_timeout got %b exp 0", o_to); end
    tests++; if (o_stalls != 2) begin fails++; $display("FAIL lw_stall_cycles got %0d exp 2", o_stalls); end
    tests++; if (o_reqs != 1) begin fails++; $display("FAIL lw_req_cycles got %0d exp 1", o_reqs); end
    tests++; if (o_be !== 4'b1111) begin fails++; $display("FAIL lw_be got %b exp 1111", o_be); end
    tests++; if (o_addr !== 32'h100) begin fails++; $display("FAIL lw_addr got %h exp 100", o_addr); end
    tests++; if (o_we !== 1'b0) begin fails++; $display("FAIL lw_we got %b exp 0", o_we); end
    tests++; if (rdata_MEM !== 32'hDEADBEEF) begin fails++; $display("FAIL lw_rdata got %h exp deadbeef", rdata_MEM); end
    tests++; if (bus.bus_req !== 1'b0) begin fails++; $display("FAIL lw_req_done got %b exp 0", bus.bus_req); end
  endtask

  task automatic test_lb_lbu;
    @(negedge clk);
    run_access(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 0, 32'h80FFFFFF,
               o_stalls, o_reqs, o_be, o_addr, o_wd, o_we, o_stable, o_to);
    tests++; if (o_be !== 4'b1000) begin fails++; $display("FAIL lb_be got %b exp 1000", o_be); end
    tests++; if (o_addr !== 32'h100) begin fails++; $display("FAIL lb_addr got %h exp 100", o_addr); end
    tests++; if (rdata_MEM !== 32'hFFFFFF80) begin fails++; $display("FAIL lb_rdata got %h exp ffffff80", rdata_MEM); end
    @(negedge clk);
    run_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 0, 32'h80FFFFFF,
               o_stalls, o_reqs, o_be, o_addr, o_wd, o_we, o_stable, o_to);
    tests++; if (rdata_MEM !== 32'h00000080) begin fails++; $display("FAIL lbu_rdata got %h exp 00000080", rdata_MEM); end
  endtask

  task automatic test_stores;
    @(negedge clk);
    run_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 0, 32'hFFFFFFFF,
               o_stalls, o_reqs, o_be, o_addr, o_wd, o_we, o_stable, o_to);
    tests++; if (o_be !== 4'b1100) begin fails++; $display("FAIL sh_be got %b exp 1100", o_be); end
    tests++; if (o_wd !== 32'hABCDABCD) begin fails++; $display("FAIL sh_wdata got %h exp abcdabcd", o_wd); end
    tests++; if (o_addr !== 32'h200) begin fails++; $display("FAIL sh_addr got %h exp 200", o_addr); end
    tests++; if (o_we !== 1'b1) begin fails++; $display("FAIL sh_we got %b exp 1", o_we); end
    tests++; if (rdata_MEM !== 32'h00000080) begin fails++; $display("FAIL sh_rdata_held got %h exp 00000080", rdata_MEM); end
    @(negedge clk);
    run_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h101, 32'h000000A5, 0, 32'h0,
               o_stalls, o_reqs, o_be, o_addr, o_wd, o_we, o_stable, o_to);
    tests++; if (o_be !== 4'b0010) begin fails++; $display("FAIL sb_be got %b exp 0010", o_be); end
    tests++; if (o_wd !== 32'hA5A5A5A5) begin fails++; $display("FAIL sb_wdata got %h exp a5a5a5a5", o_wd); end
  endtask

  task automatic test_halves;
    @(negedge clk);
    run_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 0, 32'h12348765,
               o_stalls, o_reqs, o_be, o_addr, o_wd, o_we, o_stable, o_to);
    tests++; if (o_be !== 4'b0011) begin fails++; $display("FAIL lh_be got %b exp 0011", o_be); end
    tests++; if (rdata_MEM !== 32'hFFFF8765) begin fails++; $display("FAIL lh_rdata got %h exp ffff8765", rdata_MEM); end
  endtask

  task automatic test_ack_delay;
    @(negedge clk);
    run_access(1'b1, 1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 2, 32'h80017F00,
               o_stalls, o_reqs, o_be, o_addr, o_wd, o_we, o_stable, o_to);
    tests++; if (o_to !== 1'b0) begin fails++; $display("FAIL delay_timeout got %b exp 0", o_to); end
    tests++; if (o_stalls != 4) begin fails++; $display("FAIL delay_stall_cycles got %0d exp 4", o_stalls); end
    tests++; if (o_reqs != 3) begin fails++; $display("FAIL delay_req_cycles got %0d exp 3", o_reqs); end
    tests++; if (o_stable !== 1'b1) begin fails++; $display("FAIL delay_bus_stable got %b exp 1", o_stable); end
    tests++; if (o_be !== 4'b1100) begin fails++; $display("FAIL delay_be got %b exp 1100", o_be); end
    tests++; if (rdata_MEM !== 32'h00008001) begin fails++; $display("FAIL lhu_rdata got %h exp 00008001", rdata_MEM); end
  endtask

  task automatic test_write_wins;
    @(negedge clk);
    run_access(1'b1, 1'b1, 2'b10, 1'b0, 32'h400, 32'h11223344, 0, 32'h55555555,
               o_stalls, o_reqs, o_be, o_addr, o_wd, o_we, o_stable, o_to);
    tests++; if (o_we !== 1'b1) begin fails++; $display("FAIL rw_we got %b exp 1", o_we); end
    tests++; if (o_wd !== 32'h11223344) begin fails++; $display("FAIL rw_wdata got %h exp 11223344", o_wd); end
    tests++; if (rdata_MEM !== 32'h00008001) begin fails++; $display("FAIL rw_rdata_held got %h exp 00008001", rdata_MEM); end
  endtask

  task automatic test_ack_idle;
    @(negedge clk);
    bus.bus_ack = 1'b1;
    bus.bus_rdata = 32'h77777777;
    @(negedge clk); #1;
    tests++; if (bus.bus_req !== 1'b0) begin fails++; $display("FAIL idle_ack_req got %b exp 0", bus.bus_req); end
    tests++; if (rdata_MEM !== 32'h00008001) begin fails++; $display("FAIL idle_ack_rdata got %h exp 00008001", rdata_MEM); end
    bus.bus_ack = 1'b0;
  endtask

  task automatic test_back_to_back;
    int gap_ok;
    @(negedge clk);
    run_access(1'b0, 1'b1, 2'b10, 1'b0, 32'h300, 32'hCAFEF00D, 0, 32'h0,
               o_stalls, o_reqs, o_be, o_addr, o_wd, o_we, o_stable, o_to);
    tests++; if (o_reqs != 1) begin fails++; $display("FAIL b2b_sw_req_cycles got %0d exp 1", o_reqs); end
    mem_read_MEM = 1'b1; mem_size_MEM = 2'b10; mem_unsigned_MEM = 1'b0; addr_MEM = 32'h304;
    #1;
    tests++; if (mem_stall_MEM !== 1'b0) begin fails++; $display("FAIL b2b_done_stall got %b exp 0", mem_stall_MEM); end
    @(negedge clk); #1;
    gap_ok = (bus.bus_req === 1'b0 && mem_stall_MEM === 1'b1) ? 1 : 0;
    tests++; if (gap_ok != 1) begin fails++; $display("FAIL b2b_idle_gap got req=%b stall=%b exp req=0 stall=1", bus.bus_req, mem_stall_MEM); end
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h304, 32'h0, 0, 32'h0BADC0DE,
               o_stalls, o_reqs, o_be, o_addr, o_wd, o_we, o_stable, o_to);
    tests++; if (o_stalls != 2) begin fails++; $display("FAIL b2b_lw_stalls got %0d exp 2", o_stalls); end
    tests++; if (o_addr !== 32'h304) begin fails++; $display("FAIL b2b_lw_addr got %h exp 304", o_addr); end
    tests++; if (rdata_MEM !== 32'h0BADC0DE) begin fails++; $display("FAIL b2b_lw_rdata got %h exp 0badc0de", rdata_MEM); end
  endtask

  task automatic test_misalign;
    @(negedge clk);
`ifdef DMEM_ALIGN_CHECK_EN
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 0, 32'h13579BDF,
               o_stalls, o_reqs, o_be, o_addr, o_wd, o_we, o_stable, o_to);
    tests++; if (o_stalls != 1) begin fails++; $display("FAIL mis_stalls got %0d exp 1", o_stalls); end
    tests++; if (o_reqs != 0) begin fails++; $display("FAIL mis_reqs got %0d exp 0", o_reqs); end
    tests++; if (misalign_MEM !== 1'b1) begin fails++; $display("FAIL mis_flag_done got %b exp 1", misalign_MEM); end
    @(negedge clk); #1;
    tests++; if (misalign_MEM !== 1'b0) begin fails++; $display("FAIL mis_flag_after got %b exp 0", misalign_MEM); end
    tests++; if (rdata_MEM !== 32'h0BADC0DE) begin fails++; $display("FAIL mis_rdata_held got %h exp 0badc0de", rdata_MEM); end
`else
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 0, 32'h13579BDF,
               o_stalls, o_reqs, o_be, o_addr, o_wd, o_we, o_stable, o_to);
    tests++; if (o_be !== 4'b1111) begin fails++; $display("FAIL unal_lw_be got %b exp 1111", o_be); end
    tests++; if (o_addr !== 32'h100) begin fails++; $display("FAIL unal_lw_addr got %h exp 100", o_addr); end
    tests++; if (misalign_MEM !== 1'b0) begin fails++; $display("FAIL unal_misalign got %b exp 0", misalign_MEM); end
    tests++; if (rdata_MEM !== 32'h13579BDF) begin fails++; $display("FAIL unal_lw_rdata got %h exp 13579bdf", rdata_MEM); end
    @(negedge clk);
    run_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h103, 32'h0, 0, 32'hFEDC1234,
               o_stalls, o_reqs, o_be, o_addr, o_wd, o_we, o_stable, o_to);
    tests++; if (o_be !== 4'b1100) begin fails++; $display("FAIL unal_lh_be got %b exp 1100", o_be); end
    tests++; if (rdata_MEM !== 32'hFFFFFEDC) begin fails++; $display("FAIL unal_lh_rdata got %h exp fffffedc", rdata_MEM); end
`endif
  endtask

  task automatic test_reset_mid_busy;
    @(negedge clk);
    mem_read_MEM = 1'b1; mem_write_MEM = 1'b0; mem_size_MEM = 2'b10; addr_MEM = 32'h600;
    @(negedge clk); #1;
    tests++; if (bus.bus_req !== 1'b1) begin fails++; $display("FAIL rst_busy_req got %b exp 1", bus.bus_req); end
    #1 rst_n = 1'b0;
    #1;
    tests++; if (bus.bus_req !== 1'b0) begin fails++; $display("FAIL rst_async_req got %b exp 0", bus.bus_req); end
    tests++; if (bus.bus_be !== 4'h0) begin fails++; $display("FAIL rst_async_be got %h exp 0", bus.bus_be); end
    tests++; if (mem_stall_MEM !== 1'b1) begin fails++; $display("FAIL rst_idle_stall got %b exp 1", mem_stall_MEM); end
    tests++; if (rdata_MEM !== 32'h0) begin fails++; $display("FAIL rst_rdata got %h exp 0", rdata_MEM); end
    mem_read_MEM = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h500, 32'h0, 0, 32'h2468ACE0,
               o_stalls, o_reqs, o_be, o_addr, o_wd, o_we, o_stable, o_to);
    tests++; if (o_stalls != 2) begin fails++; $display("FAIL rst_after_stalls got %0d exp 2", o_stalls); end
    tests++; if (rdata_MEM !== 32'h2468ACE0) begin fails++; $display("FAIL rst_after_rdata got %h exp 2468ace0", rdata_MEM); end
  endtask

  initial begin
    bus.bus_ack = 1'b0;
    bus.bus_rdata = 32'h0;
    test_reset();
    test_lw();
    test_lb_lbu();
    test_stores();
    test_halves();
    test_ack_delay();
    test_write_wins();
    test_ack_idle();
    test_back_to_back();
    test_misalign();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
